product_serializer: RTL and testbench
=====================================

Name: product_serializer

Overview:
- Reads the 16-bit product held in the accumulator/product register and shifts it out serially, MSB first, with framing strobes.
- Sits downstream of the 16-bit product register. It is the read-side counterpart to that register's clk/clk_ena/sclr_n write-side semantics.
- Provides a single-beat load handshake, a shift FSM with bit counter, and a completion pulse.

Parameters:
- WIDTH, 16, product word width; counter width is clog2(WIDTH).
- MSB_FIRST, 1, 1 = shift bit WIDTH-1 first, 0 = bit 0 first.

Ports:
- clk  input  1  system clock, rising edge.
- reset_a  input  1  asynchronous reset, active-low; forces IDLE and clears all outputs immediately.
- clk_ena  input  1  clock enable; when 0, all state, counter, shift register and outputs hold.
- sclr_n  input  1  synchronous clear, active-low.
- load  input  1  request to capture datain; accepted only when ready=1.
- datain  input  WIDTH  product word to transmit.
- ready  output  1  high only in IDLE.
- sout  output  1  serial data bit.
- sout_valid  output  1  high while sout carries a data or parity bit.
- frame_start  output  1  one-cycle pulse coinciding with the first bit.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset values (reset_a=0, asynchronous): state=IDLE, shift register=0, count=0, sout=0, sout_valid=0, frame_start=0, done=0, ready=1.
- sclr_n=0 at a rising edge gives the same result as reset.
  - It is applied regardless of clk_ena.
  - It has priority over load.
- All other transitions occur only on a rising edge with clk_ena=1.
- All outputs are registered.

FSM:
- IDLE:
  - If load=1, capture datain, set count=0, and go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT:
  - Present one bit per enabled cycle: bit WIDTH-1-count, or bit count when MSB_FIRST=0.
  - sout_valid=1.
  - frame_start=1 only when count=0.
  - When count reaches WIDTH-1: with the parity feature disabled, go to DONE; otherwise go to PARITY.
- PARITY (feature only): one bit-time with sout=parity and sout_valid=1, then go to DONE.
- DONE: done=1 for exactly one enabled cycle, sout_valid=0, ready=0, then go to IDLE.

Latency and throughput:
- load accepted at edge N: first bit is valid after edge N+1.
- Last data bit is valid after edge N+WIDTH.
- done is high after edge N+WIDTH+1; ready returns after edge N+WIDTH+2.
- Throughput is WIDTH+2 enabled cycles per word (WIDTH+3 with parity).

Boundary conditions:
- load while ready=0 (SHIFT/PARITY/DONE) is ignored: no queuing, and the captured word is unchanged.
- datain changes after capture have no effect.
- clk_ena=0 mid-frame freezes sout, sout_valid, count and the FSM. frame_start and done pulses stretch for the duration of the freeze.
- reset_a asserted mid-frame aborts the frame; done is not produced.
- The counter never wraps past WIDTH-1; an exit to PARITY or DONE is forced.
- In IDLE, sout=0.

Optional Feature:
- Macro: PRODUCT_SERIALIZER_PARITY_EN.
- Defined:
  - PARITY state is compiled in.
  - After the last data bit, one extra bit = XOR of all WIDTH captured bits (even parity) is sent with sout_valid=1.
  - done follows one cycle later.
- Undefined:
  - No PARITY state exists; DONE follows the last data bit directly.
  - Frame length is exactly WIDTH bits.

Test Plan:
- Basic shift:
  - Stimulus: after reset, load=1 with datain=16'h1234 for one cycle.
  - Required: ready drops; over 16 cycles sout = 0001_0010_0011_0100 with sout_valid=1; frame_start on the first bit only; done pulses one cycle later; ready=1 two cycles after the last bit.
- Busy load ignored:
  - Stimulus: during the 0x1234 frame, pulse load with datain=16'h1454.
  - Required: the serial stream is still 0x1234, and no second frame follows.
- Clock-enable freeze:
  - Stimulus: drop clk_ena for 3 cycles after the 5th bit of 0x1234.
  - Required: sout holds 0 (bit 11) for the freeze; the stream then resumes with bit 10=0; total enabled-cycle count is unchanged.
- Asynchronous reset mid-frame:
  - Stimulus: assert reset_a after the 8th bit.
  - Required: outputs clear immediately, no done pulse, ready=1.
  - Stimulus: next load of 16'hFFFF.
  - Required: 16 ones are sent.
- Synchronous clear:
  - Stimulus: sclr_n=0 coincident with load=1 in IDLE.
  - Required: no capture; stays IDLE with ready=1.
  - Stimulus: sclr_n=0 mid-frame.
  - Required: returns to IDLE on that edge.
- Parity (macro defined):
  - Stimulus: 0x1234 (popcount 5).
  - Required: a 17th bit = 1 with sout_valid=1, then done.
  - Stimulus: 0x0000.
  - Required: parity bit = 0.

Source files
------------

// File: rtl/product_serializer_if.sv
// Load/serial-output bundle for product_serializer: the producer drives load/datain,
// the serializer returns ready and the framed serial stream.
interface product_serializer_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] datain;
  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             done;

  modport master (output load, datain,
                  input  ready, sout, sout_valid, frame_start, done);
  modport slave  (input  load, datain,
                  output ready, sout, sout_valid, frame_start, done);
endinterface

// File: rtl/product_serializer.sv
// Serializes a captured product word with frame_start/done strobes.
// Define PRODUCT_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module product_serializer #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset_a,
  input  logic                  clk_ena,
  input  logic                  sclr_n,
  product_serializer_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PRODUCT_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY, S_DONE} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sout_q, sout_d;
  logic             vld_q, vld_d;
  logic             fs_q, fs_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [CW-1:0]    idx;

  // The captured word is never shifted, so it stays intact for the parity bit.
  assign idx = MSB_FIRST ? (LAST - cnt_q) : cnt_q;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    sout_d  = 1'b0;
    vld_d   = 1'b0;
    fs_d    = 1'b0;
    done_d  = 1'b0;
    ready_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (bus.load && ready_q) begin
          word_d  = bus.datain;
          cnt_d   = '0;
          state_d = S_SHIFT;
          ready_d = 1'b0;
        end
      end
      S_SHIFT: begin
        sout_d = word_q[idx];
        vld_d  = 1'b1;
        fs_d   = (cnt_q == '0);
        if (cnt_q == LAST) begin
`ifdef PRODUCT_SERIALIZER_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef PRODUCT_SERIALIZER_PARITY_EN
      S_PARITY: begin
        sout_d  = ^word_q;
        vld_d   = 1'b1;
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronous clear wins over clk_ena and load, mirroring the async reset values.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (!sclr_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      cnt_q   <= '0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      fs_q    <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else if (clk_ena) begin
      state_q <= state_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sout_q  <= sout_d;
      vld_q   <= vld_d;
      fs_q    <= fs_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready       = ready_q;
  assign bus.sout        = sout_q;
  assign bus.sout_valid  = vld_q;
  assign bus.frame_start = fs_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_product_serializer.sv
// Bench for product_serializer: frame-position model checked every cycle plus directed
// literal checks on the reassembled serial words.
module tb_product_serializer;
  localparam int W = 16;
`ifdef PRODUCT_SERIALIZER_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk = 1'b0;
  logic reset_a = 1'b0;
  logic clk_ena = 1'b1;
  logic sclr_n = 1'b1;

  product_serializer_if #(.WIDTH(W)) bus ();

  product_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset_a(reset_a), .clk_ena(clk_ena), .sclr_n(sclr_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Model: pos = enabled edges since the word was accepted; -1 means idle and ready.
  int               pos = -1;
  logic [W-1:0]     m_word = '0;
  int               n_done = 0;
  logic [W-1:0]     rx_word = '0;
  int               rx_n = 0;
  logic             par_bit = 1'b0;

  always begin
    logic adv;
    logic e_sout;
    @(posedge clk);
    adv = reset_a && sclr_n && clk_ena;
    if (!reset_a || !sclr_n) pos = -1;
    else if (clk_ena) begin
      if (pos < 0) begin
        if (bus.load) begin
          pos = 0;
          m_word = bus.datain;
        end
      end else if (pos == FLEN + 1) pos = -1;
      else pos++;
    end
    #1;
    e_sout = 1'b0;
    if (pos >= 1 && pos <= W) e_sout = m_word[W - pos];
    else if (pos == W + 1 && FLEN > W) e_sout = ^m_word;
    chk("ready", bus.ready, (pos < 0));
    chk("sout_valid", bus.sout_valid, (pos >= 1 && pos <= FLEN));
    chk("frame_start", bus.frame_start, (pos == 1));
    chk("done", bus.done, (pos == FLEN + 1));
    chk("sout", bus.sout, e_sout);
    if (adv && pos >= 1 && pos <= W) begin
      if (pos == 1) rx_n = 0;
      rx_word = {rx_word[W-2:0], bus.sout};
      rx_n++;
    end
    if (adv && pos == W + 1 && FLEN > W) par_bit = bus.sout;
    if (adv && pos == FLEN + 1) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] w);
    @(negedge clk);
    bus.load = 1'b1;
    bus.datain = w;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (rx_n < n && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bits_timeout", (t < 100), 1);
  endtask

  task automatic wait_done(input int prev);
    int t = 0;
    while (n_done == prev && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_done_timeout", (t < 100), 1);
  endtask

  initial begin
    int d0;
    bus.load = 1'b0;
    bus.datain = '0;
    tick(3);
    chk("reset_ready", bus.ready, 1);
    chk("reset_valid", bus.sout_valid, 0);
    chk("reset_done", bus.done, 0);
    reset_a = 1'b1;
    tick(2);

    // Basic frame with an ignored busy load of a different word.
    d0 = n_done;
    rx_n = 0;
    send(16'h1234);
    chk("ready_drop", bus.ready, 0);
    tick(5);
    send(16'h1454);
    wait_done(d0);
    chk("basic_word", rx_word, 16'h1234);
    chk("basic_bits", rx_n, 16);
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    chk("parity_1234", par_bit, 1);
`endif
    chk("ready_after_done", bus.ready, 0);
    tick(1);
    chk("ready_return", bus.ready, 1);
    tick(20);
    chk("no_second_frame", n_done, d0 + 1);

    // Clock-enable freeze after the fifth bit (bit 11 = 0).
    d0 = n_done;
    rx_n = 0;
    send(16'h1234);
    wait_bits(5);
    clk_ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("freeze_sout", bus.sout, 0);
      chk("freeze_valid", bus.sout_valid, 1);
      chk("freeze_bits", rx_n, 5);
    end
    clk_ena = 1'b1;
    wait_done(d0);
    chk("freeze_word", rx_word, 16'h1234);

    // Asynchronous reset after the eighth bit.
    d0 = n_done;
    rx_n = 0;
    send(16'hABCD);
    wait_bits(8);
    #2 reset_a = 1'b0;
    #1;
    chk("areset_valid", bus.sout_valid, 0);
    chk("areset_ready", bus.ready, 1);
    chk("areset_sout", bus.sout, 0);
    tick(2);
    reset_a = 1'b1;
    tick(25);
    chk("abort_no_done", n_done, d0);
    rx_n = 0;
    send(16'hFFFF);
    wait_done(d0);
    chk("ones_word", rx_word, 16'hFFFF);
    tick(2);

    // Synchronous clear beats load in idle.
    @(negedge clk);
    sclr_n = 1'b0;
    bus.load = 1'b1;
    bus.datain = 16'h5555;
    @(negedge clk);
    sclr_n = 1'b1;
    bus.load = 1'b0;
    chk("sclr_idle_ready", bus.ready, 1);
    tick(3);
    chk("sclr_idle_valid", bus.sout_valid, 0);

    // Synchronous clear mid-frame.
    d0 = n_done;
    rx_n = 0;
    send(16'h00F0);
    wait_bits(4);
    sclr_n = 1'b0;
    @(negedge clk);
    sclr_n = 1'b1;
    chk("sclr_mid_ready", bus.ready, 1);
    chk("sclr_mid_valid", bus.sout_valid, 0);
    tick(25);
    chk("sclr_no_done", n_done, d0);

    // All-zero word.
    rx_n = 0;
    par_bit = 1'b1;
    send(16'h0000);
    wait_done(d0);
    chk("zero_word", rx_word, 16'h0000);
`ifdef PRODUCT_SERIALIZER_PARITY_EN
    chk("parity_0000", par_bit, 0);
`endif
    tick(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
